ysyx_24100005_ifu: RTL
======================

Name: ysyx_24100005_ifu

Overview:
- Instruction fetch unit directly upstream of the single-cycle core top. It drives the core's `inst` input and the matching PC.
- Issues one request at a time on a request/response instruction-memory port that may stall, and holds the fetched word until the core commits it.
- Takes the core's dynamic next PC on commit.
- Detects misaligned fetch targets and memory timeouts, then parks in a sticky fault state.

Parameters:
RESET_PC, 32'h8000_0000, fetch address after reset
TIMEOUT, 255, max cycles in WAIT before a timeout fault (1..65535)
CNT_W, 16, width of the wait-cycle counter

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-low reset (0 = reset)
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  32  fetch byte address, word aligned
imem_req_ready  input  1  memory accepts request this cycle
imem_resp_valid  input  1  response data valid
imem_resp_data  input  32  fetched instruction word
imem_resp_err  input  1  access error, qualified by imem_resp_valid
inst_valid  output  1  inst/inst_pc hold a fetched instruction
inst  output  32  instruction word to core
inst_pc  output  32  address of inst
inst_ready  input  1  core commits inst this cycle
dnpc  input  32  core's next PC, sampled on commit
fault  output  1  sticky fault flag
fault_cause  output  2  00 none, 01 misaligned, 10 bus error, 11 timeout
fault_pc  output  32  PC that caused the fault

Behaviour:
- FSM states: REQ, WAIT, HOLD, FAULT.
- Reset (rst==0, asynchronous), all outputs forced:
  - state=REQ, pc=RESET_PC, inst=32'h0, inst_pc=RESET_PC.
  - inst_valid=0, fault=0, fault_cause=00, fault_pc=0, wait counter=0.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready=1: go to WAIT, clear the counter.
  - Otherwise stay in REQ; addr is held stable while valid is high.
- WAIT:
  - imem_req_valid=0. imem_resp_valid is sampled only in WAIT; a response in the same cycle as request acceptance is ignored.
  - resp_valid & !resp_err: latch inst=resp_data and inst_pc=pc, go to HOLD.
  - resp_valid & resp_err: go to FAULT with cause 10, fault_pc=pc.
  - No response: counter increments. When counter==TIMEOUT with no response, go to FAULT with cause 11.
  - A late response arriving in FAULT is ignored.
- HOLD:
  - inst_valid=1; inst and inst_pc are stable until commit.
  - On inst_ready=1: pc<=dnpc, inst_valid drops next cycle.
  - If dnpc[1:0]!=0: go to FAULT with cause 01, fault_pc=dnpc. Otherwise go to REQ.
- FAULT:
  - fault=1, inst_valid=0, imem_req_valid=0. Sticky until reset.
  - Cause and fault_pc are written once, on entry.
- Throughput: 3 cycles per instruction minimum (REQ, WAIT, HOLD) with zero-wait memory and an always-ready core.
- Width rules:
  - pc arithmetic is done by the core; the IFU does no increment.
  - pc is 32-bit and wraps naturally: dnpc=32'hFFFF_FFFC is legal.
- Simultaneous events:
  - inst_ready outside HOLD is ignored.
  - dnpc is ignored unless inst_valid & inst_ready.
- Reset mid-operation:
  - Any outstanding memory transaction is abandoned.
  - The memory model must tolerate a dropped response, which the IFU will not sample until its next WAIT.
- inst is not cleared on leaving HOLD. Consumers must qualify it with inst_valid.

Decomposition:
- Shared package ysyx_24100005_pkg holds:
  - state encoding: REQ=2'd0, WAIT=2'd1, HOLD=2'd2, FAULT=2'd3.
  - fault cause constants: FC_NONE, FC_MISALIGN, FC_BUSERR, FC_TIMEOUT.
  - RESET_PC default constant.
- One sub-module: the existing register primitive ysyx_24100005_Reg, instantiated for pc with RESET_PC and wen = commit.
- The FSM, counter and output latches are inline.

Test Plan:
- Reset release, memory ready every cycle with 1-cycle response, core always ready → first imem_req_addr=0x8000_0000; inst_valid high in cycle 3; inst_pc=0x8000_0000.
- Hold imem_req_ready=0 for 5 cycles → req_valid stays 1 and addr stays 0x8000_0000; WAIT is entered exactly one cycle after ready rises.
- Core holds inst_ready=0 for 4 cycles in HOLD, then commits with dnpc=0x8000_0100 → inst stays stable throughout; next request addr=0x8000_0100.
- Commit with dnpc=0x8000_0102 → fault=1, cause=01, fault_pc=0x8000_0102; no further imem_req_valid until reset.
- TIMEOUT=4, memory never responds → fault cause=11 after 4 WAIT cycles; a later resp_valid is ignored.
- resp_err=1 on the third fetch → cause=10, fault_pc equals that fetch's PC. Then assert rst=0 asynchronously mid-cycle → fault clears immediately and fetch restarts at 0x8000_0000.

Source files
------------

// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the ysyx_24100005 instruction fetch unit.
package ysyx_24100005_pkg;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } ifu_state_t;

    // Fault cause codes reported on fault_cause
    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_BUSERR   = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24100005_Reg.sv
// Generic register with write enable and asynchronous active-low reset.
module ysyx_24100005_Reg #(
    parameter int unsigned       WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    // Load din when enabled, return to RESET_VAL on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one outstanding request, holds the fetched word until
// the core commits it, then follows the core's dnpc. Misaligned targets, bus
// errors and response timeouts park the unit in a sticky fault state.
module ysyx_24100005_ifu
    import ysyx_24100005_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic [31:0] dnpc,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    ifu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      inst_pc_q, inst_pc_d;
    logic [1:0]       cause_q, cause_d;
    logic [31:0]      fpc_q, fpc_d;
    logic [31:0]      pc;
    logic             commit;

    // The core only commits while we present a valid instruction
    assign commit = (state_q == HOLD) && inst_ready;

    ysyx_24100005_Reg #(
        .WIDTH    (32),
        .RESET_VAL(RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .din (dnpc),
        .dout(pc),
        .wen (commit)
    );

    // State, wait counter and output latches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= REQ;
            cnt_q     <= '0;
            inst_q    <= 32'h0;
            inst_pc_q <= RESET_PC;
            cause_q   <= FC_NONE;
            fpc_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cause_q   <= cause_d;
            fpc_q     <= fpc_d;
        end
    end

    // Next-state logic; fault cause/pc are only written on the way into FAULT
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cause_d   = cause_q;
        fpc_d     = fpc_q;
        unique case (state_q)
            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (imem_resp_err) begin
                        state_d = FAULT;
                        cause_d = FC_BUSERR;
                        fpc_d   = pc;
                    end else begin
                        state_d   = HOLD;
                        inst_d    = imem_resp_data;
                        inst_pc_d = pc;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    // Give up once TIMEOUT silent cycles have elapsed
                    if (cnt_d == TIMEOUT_CNT) begin
                        state_d = FAULT;
                        cause_d = FC_TIMEOUT;
                        fpc_d   = pc;
                    end
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    if (dnpc[1:0] != 2'b00) begin
                        state_d = FAULT;
                        cause_d = FC_MISALIGN;
                        fpc_d   = dnpc;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state_q == HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fault          = (state_q == FAULT);
    assign fault_cause    = cause_q;
    assign fault_pc       = fpc_q;

endmodule
